wb_arbiter2: RTL

- Two-master Wishbone arbiter in front of WB_intercon, sharing the single slave bus between the CPU (master 0) and a disk-to-RAM DMA engine (master 1).
- Grants are round-robin and held for exactly one transfer.
- A bus watchdog terminates transfers that a slave never ACKs, and records the fault for software and debug display.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_watchdog.sv | 41 ++++
 rtl/wb_arbiter2.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the bus arbiter and its helpers.
//   WB_AW / WB_DW   : address and data widths of the shared slave bus
//   arb_state_e     : arbiter state encoding (idle, granted to m0, granted to m1)
//   TO_DATA_DEFAULT : read data returned to a master whose transfer timed out
package wb_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;

  localparam logic [WB_DW-1:0] TO_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_G0   = 2'd1,
    ARB_G1   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts cycles spent waiting for an ACK and flags when the limit is reached.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   en_i       : count this cycle (transfer in progress, no ACK yet)
//   clr_i      : return the counter to zero (takes priority over en_i)
//   expired_o  : counter has reached TIMEOUT-1; qualify with the wait condition externally
module wb_watchdog #(
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] Limit = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == Limit);

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with a bus watchdog.
//   clk, rst                          : clock, synchronous active-high reset
//   m0_* / m1_*                       : master ports (STB held until ACK)
//   s_*                               : shared slave bus towards WB_intercon
//   gnt                               : one-hot current grant {m1,m0}, 00 when idle
//   err, err_master, err_clr          : sticky timeout flag, culprit master, clear
// A grant lasts exactly one transfer and is always followed by an idle cycle, so a master
// that keeps STB high through its ACK is arbitrated again as a fresh request.
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int unsigned       TO_W    = 8,
  parameter int unsigned       TIMEOUT = 200,
  parameter logic [WB_DW-1:0]  TO_DATA = TO_DATA_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_STB,
  input  logic             m0_WE,
  input  logic [WB_AW-1:0] m0_ADDR,
  input  logic [WB_DW-1:0] m0_DAT_I,
  output logic [WB_DW-1:0] m0_DAT_O,
  output logic             m0_ACK,
  input  logic             m1_STB,
  input  logic             m1_WE,
  input  logic [WB_AW-1:0] m1_ADDR,
  input  logic [WB_DW-1:0] m1_DAT_I,
  output logic [WB_DW-1:0] m1_DAT_O,
  output logic             m1_ACK,
  output logic             s_STB,
  output logic             s_WE,
  output logic [WB_AW-1:0] s_ADDR,
  output logic [WB_DW-1:0] s_DAT_O,
  input  logic [WB_DW-1:0] s_DAT_I,
  input  logic             s_ACK,
  output logic [1:0]       gnt,
  output logic             err,
  output logic             err_master,
  input  logic             err_clr
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       err_q, err_d;
  logic       err_master_q, err_master_d;

  logic       granted, sel, cur_stb, done, timeout, wd_expired;
  logic       ack_out;
  logic [WB_DW-1:0] rd_data;

  assign granted = (state_q != ARB_IDLE);
  assign sel     = (state_q == ARB_G1);
  assign cur_stb = sel ? m1_STB : m0_STB;
  assign done    = granted & cur_stb & s_ACK;
  // A real ACK in the expiry cycle wins over the timeout.
  assign timeout = granted & cur_stb & ~s_ACK & wd_expired;

  wb_watchdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (granted & ~s_ACK),
    .clr_i     (~granted | ~cur_stb | done | timeout),
    .expired_o (wd_expired)
  );

  // Next state, round-robin bookkeeping and error capture.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    err_d        = err_q;
    err_master_d = err_master_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (m0_STB && m1_STB) begin
          state_d = last_q ? ARB_G0 : ARB_G1;
        end else if (m0_STB) begin
          state_d = ARB_G0;
        end else if (m1_STB) begin
          state_d = ARB_G1;
        end
      end
      ARB_G0, ARB_G1: begin
        // Abort (STB dropped) returns to idle without touching last.
        if (!cur_stb || done || timeout) begin
          state_d = ARB_IDLE;
        end
        if (done || timeout) begin
          last_d = sel;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (timeout) begin
      err_d        = 1'b1;
      err_master_d = sel;
    end
  end

  // Forwarding muxes; everything idles at zero when nothing is granted.
  assign rd_data = timeout ? TO_DATA : s_DAT_I;
  assign ack_out = (done | timeout) & ~rst;

  always_comb begin
    s_STB    = 1'b0;
    s_WE     = 1'b0;
    s_ADDR   = '0;
    s_DAT_O  = '0;
    m0_ACK   = 1'b0;
    m0_DAT_O = '0;
    m1_ACK   = 1'b0;
    m1_DAT_O = '0;
    if (granted) begin
      s_STB   = cur_stb & ~timeout & ~rst;
      s_WE    = sel ? m1_WE : m0_WE;
      s_ADDR  = sel ? m1_ADDR : m0_ADDR;
      s_DAT_O = sel ? m1_DAT_I : m0_DAT_I;
      if (sel) begin
        m1_ACK   = ack_out;
        m1_DAT_O = rd_data;
      end else begin
        m0_ACK   = ack_out;
        m0_DAT_O = rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_q       <= 1'b1;
      err_q        <= 1'b0;
      err_master_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      err_q        <= err_d;
      err_master_q <= err_master_d;
    end
  end

  assign gnt        = {state_q == ARB_G1, state_q == ARB_G0};
  assign err        = err_q;
  assign err_master = err_master_q;

endmodule
